// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit holding register among NREQ requesters,
// with valid/ready output. Optional stall watchdog enabled by macro RRARB_WDOG_EN.
module rr_reg_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DW     = 8,
   parameter int unsigned WDOG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [DW-1:0]        q,
   output logic                 q_valid,
   input  logic                 q_ready
`ifdef RRARB_WDOG_EN
   ,
   output logic                 wdog_err
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] StEmpty = 1'b0;
   localparam logic [0:0] StFull  = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [DW-1:0]   q_q, q_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   last_ptr_q, last_ptr_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [DW-1:0]   win_data;
   int unsigned     scan_idx;
   logic            load;

   // Scan starts one past the last winner so every requester is reached within NREQ loads.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         scan_idx = (32'(last_ptr_q) + off) % NREQ;
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[PW-1:0];
         end
      end
   end

   assign win_data = wdata[win_idx*DW +: DW];
   assign load     = win_found && ((state_q == StEmpty) || q_ready);

`ifdef RRARB_WDOG_EN
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_err_q, wdog_err_d;
   logic              stall;
   logic              wdog_fire;

   assign stall     = (state_q == StFull) && !q_ready;
   assign wdog_fire = stall && (wdog_cnt_q == {WDOG_W{1'b1}});

   always_comb begin
      wdog_cnt_d = '0;
      wdog_err_d = wdog_fire;
      if (stall && !wdog_fire) begin
         wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`endif

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      gnt_d      = '0;
      last_ptr_d = last_ptr_q;
      if (load) begin
         state_d        = StFull;
         q_d            = win_data;
         gnt_d[win_idx] = 1'b1;
         last_ptr_d     = win_idx;
      end else if ((state_q == StFull) && q_ready) begin
         state_d = StEmpty;
`ifdef RRARB_WDOG_EN
      end else if (wdog_fire) begin
         state_d = StEmpty;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         q_q        <= '0;
         gnt_q      <= '0;
         last_ptr_q <= PW'(NREQ - 1);
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         gnt_q      <= gnt_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   assign q       = q_q;
   assign q_valid = (state_q == StFull);
   assign gnt     = gnt_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter: expected outputs queued per step, compared after each edge.
module tb_rr_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic        q_valid;
   logic        q_ready;
`ifdef RRARB_WDOG_EN
   logic        wdog_err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] q;
      logic       qv;
      logic       chk_q;
      logic       err;
   } exp_t;

   exp_t sb[$];

   rr_reg_arbiter #(
      .NREQ   (4),
      .DW     (8),
      .WDOG_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wdata    (wdata),
      .gnt      (gnt),
      .q        (q),
      .q_valid  (q_valid),
      .q_ready  (q_ready)
`ifdef RRARB_WDOG_EN
      ,
      .wdog_err (wdog_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                       input logic [3:0] eg, input logic [7:0] eq, input logic ev,
                       input logic cq, input logic ee, input string tag);
      exp_t e;
      rst     = r;
      req     = rq;
      q_ready = rdy;
      sb.push_back('{gnt: eg, q: eq, qv: ev, chk_q: cq, err: ee});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (gnt === e.gnt) else begin
         errors++;
         $error("FAIL %s gnt: got %b expected %b", tag, gnt, e.gnt);
      end
      checks++;
      assert (q_valid === e.qv) else begin
         errors++;
         $error("FAIL %s q_valid: got %b expected %b", tag, q_valid, e.qv);
      end
      if (e.chk_q) begin
         checks++;
         assert (q === e.q) else begin
            errors++;
            $error("FAIL %s q: got %h expected %h", tag, q, e.q);
         end
      end
`ifdef RRARB_WDOG_EN
      checks++;
      assert (wdog_err === e.err) else begin
         errors++;
         $error("FAIL %s wdog_err: got %b expected %b", tag, wdog_err, e.err);
      end
`endif
   endtask

   initial begin
      logic [3:0] eg;
      logic [7:0] eq;
      rst     = 1'b1;
      req     = 4'b1111;
      q_ready = 1'b0;
      for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'(8'h10 + i);

      // Reset held two cycles with all requests up
      step(1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, "reset0");
      step(1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, "reset1");

      // Rotation, starting from requester 0 after reset
      for (int i = 0; i < 5; i++) begin
         eg = 4'(4'b0001 << (i % 4));
         eq = 8'(8'h10 + (i % 4));
         step(1'b0, 4'b1111, 1'b1, eg, eq, 1'b1, 1'b1, 1'b0, "rotate");
      end
      step(1'b0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, "drain");
      step(1'b0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, "idle_ready");

      // Single request
      wdata[23:16] = 8'hA5;
      step(1'b0, 4'b0100, 1'b1, 4'b0100, 8'hA5, 1'b1, 1'b1, 1'b0, "single");
      step(1'b0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, "single_drain");
      wdata[23:16] = 8'h12;

      // Backpressure: load 11, stall 5 cycles with req=1001, then resume
      step(1'b0, 4'b0010, 1'b1, 4'b0010, 8'h11, 1'b1, 1'b1, 1'b0, "bp_load");
      for (int i = 0; i < 5; i++)
         step(1'b0, 4'b1001, 1'b0, 4'b0000, 8'h11, 1'b1, 1'b1, 1'b0, "bp_hold");
      step(1'b0, 4'b1001, 1'b1, 4'b1000, 8'h13, 1'b1, 1'b1, 1'b0, "bp_resume");
      step(1'b0, 4'b1001, 1'b1, 4'b0001, 8'h10, 1'b1, 1'b1, 1'b0, "bp_wrap");

      // Mid-operation reset: pointer left at 1, so continuation would pick 2
      step(1'b0, 4'b0010, 1'b1, 4'b0010, 8'h11, 1'b1, 1'b1, 1'b0, "mr_load");
      step(1'b0, 4'b0110, 1'b0, 4'b0000, 8'h11, 1'b1, 1'b1, 1'b0, "mr_hold");
      step(1'b1, 4'b0110, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, "mr_reset");
      step(1'b0, 4'b0110, 1'b1, 4'b0010, 8'h11, 1'b1, 1'b1, 1'b0, "mr_regrant");

      // Long stall of 20 cycles
      for (int k = 1; k <= 20; k++) begin
`ifdef RRARB_WDOG_EN
         step(1'b0, 4'b0000, 1'b0, 4'b0000, 8'h11, (k < 16), (k < 16), (k == 16), "wdog");
`else
         step(1'b0, 4'b0000, 1'b0, 4'b0000, 8'h11, 1'b1, 1'b1, 1'b0, "stall");
`endif
      end
      step(1'b0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, "final_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
